game_tick_gen: RTL

Parametrised game-timing generator for the Tetris core, replacing the fixed 1 Hz gravity clock. It produces a one-cycle gravity tick whose period shrinks with the current level, with a soft-drop fast mode and a run/pause/idle control FSM. It optionally produces a seconds tick and an elapsed-seconds counter for the HUD. It sits between the input/control logic and the piece-movement FSM.

---
 rtl/game_tick_pkg.sv | 38 +++
 rtl/tick_divider.sv | 36 +++
 rtl/game_tick_gen.sv | 122 ++++++++++++
 3 files changed

// File: rtl/game_tick_pkg.sv
// Shared types and helpers for the game timing generator: control states and
// level-to-period arithmetic.
package game_tick_pkg;

  localparam int LEVEL_W_DEF = 5;

  // 64-bit arithmetic holds any LEVEL_W + clog2(LEVEL_STEP+1) product used in practice.
  localparam int CALC_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED
  } tick_state_t;

  function automatic logic [CALC_W-1:0] level_period(
    input logic [CALC_W-1:0] level,
    input logic [CALC_W-1:0] base,
    input logic [CALC_W-1:0] step,
    input logic [CALC_W-1:0] min
  );
    logic [CALC_W-1:0] prod;
    prod = level * step;
    if (prod > base - min) return min;
    return base - prod;
  endfunction

  function automatic logic [CALC_W-1:0] soft_period(
    input logic [CALC_W-1:0] lp,
    input int unsigned       shift
  );
    logic [CALC_W-1:0] sp;
    sp = lp >> shift;
    if (sp == '0) sp = 1;
    return sp;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running period divider with a registered one-cycle tick; wraps as soon as
// the count reaches period-1, so a shortened period fires on the next cycle.
module tick_divider #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] period,
  output logic         tick,
  output logic         wrap
);

  logic [W-1:0] cnt;

  assign wrap = en && !clr && (({1'b0, cnt} + (W+1)'(1)) >= {1'b0, period});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      cnt  <= wrap ? '0 : cnt + W'(1);
      tick <= wrap;
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/game_tick_gen.sv
// Level-scaled gravity tick generator with soft drop and run/pause/idle control.
// Define GAME_TICK_SECONDS_EN to add the seconds tick and elapsed-seconds counter.
module game_tick_gen
  import game_tick_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 25000000,
  parameter int unsigned LEVEL_STEP  = 2000000,
  parameter int unsigned MIN_PERIOD  = 2500000,
  parameter int unsigned LEVEL_W     = LEVEL_W_DEF,
  parameter int unsigned SOFT_SHIFT  = 3,
  parameter int unsigned SEC_PERIOD  = 100000000,
  parameter int unsigned SEC_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               stop,
  input  logic [LEVEL_W-1:0] level,
  input  logic               soft_drop,
  output logic               grav_tick,
  output logic               running,
  output logic               sec_tick,
  output logic [SEC_W-1:0]   elapsed_s
);

  localparam int CNT_W = $clog2(BASE_PERIOD + 1);

  tick_state_t state;
  logic [CNT_W-1:0] ep_d, ep_q;
  logic div_en, div_clr;
  logic grav_wrap_unused;

  // NOTE: ep_d gets its default first so the conditional override cannot infer a latch.
  always_comb begin
    ep_d = CNT_W'(level_period(CALC_W'(level), CALC_W'(BASE_PERIOD),
                               CALC_W'(LEVEL_STEP), CALC_W'(MIN_PERIOD)));
    if (soft_drop)
      ep_d = CNT_W'(soft_period(level_period(CALC_W'(level), CALC_W'(BASE_PERIOD),
                                             CALC_W'(LEVEL_STEP), CALC_W'(MIN_PERIOD)),
                                SOFT_SHIFT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ep_q <= CNT_W'(BASE_PERIOD);
    else     ep_q <= ep_d;
  end

  // Counting stops in the very cycle pause rises, which also drops any pending tick.
  assign div_en  = (state == RUN) && !pause && !stop && !start;
  assign div_clr = (state == IDLE) || start || stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      running <= 1'b0;
    end else if (stop) begin
      state   <= IDLE;
      running <= 1'b0;
    end else if (start) begin
      if (state != IDLE && pause) begin
        state   <= PAUSED;
        running <= 1'b0;
      end else begin
        state   <= RUN;
        running <= 1'b1;
      end
    end else begin
      case (state)
        RUN: if (pause) begin
          state   <= PAUSED;
          running <= 1'b0;
        end
        PAUSED: if (!pause) begin
          state   <= RUN;
          running <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  tick_divider #(.W(CNT_W)) u_grav (
    .clk    (clk),
    .rst    (rst),
    .en     (div_en),
    .clr    (div_clr),
    .period (ep_q),
    .tick   (grav_tick),
    .wrap   (grav_wrap_unused)
  );

`ifdef GAME_TICK_SECONDS_EN
  localparam int SEC_CNT_W = $clog2(SEC_PERIOD + 1);

  logic sec_wrap;

  tick_divider #(.W(SEC_CNT_W)) u_sec (
    .clk    (clk),
    .rst    (rst),
    .en     (div_en),
    .clr    (div_clr),
    .period (SEC_CNT_W'(SEC_PERIOD)),
    .tick   (sec_tick),
    .wrap   (sec_wrap)
  );

  // Counting on the wrap keeps elapsed_s in step with the sec_tick it accompanies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           elapsed_s <= '0;
    else if (div_clr)                  elapsed_s <= '0;
    else if (sec_wrap && ~&elapsed_s)  elapsed_s <= elapsed_s + SEC_W'(1);
  end
`else
  assign sec_tick  = 1'b0;
  assign elapsed_s = '0;
`endif

endmodule
